shared_hpc3_mul_gfn: RTL and testbench

Parametrised, first-order-and-up masked multiplier over GF(2^N) using the HPC3 gadget, with a one-deep elastic pipeline stage and valid/ready handshakes. It replaces the fixed GF(4) square-scale-multiply gadget for masked S-box datapaths that need wider fields (GF(16), GF(256)) or backpressure. The block registers the previous-x shares internally, so the caller no longer supplies delayed operands. Output shares recombine (XOR) to x·y in GF(2^N).

---
 rtl/shared_hpc3_mul_gfn.sv | 118 +++++++++++
 tb/tb_shared_hpc3_mul_gfn.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shared_hpc3_mul_gfn.sv
// Masked GF(2^N) multiplier (HPC3 gadget) with one elastic register stage. Latency 1 cycle;
// a stalled result holds QxDO and drops InReadyxSO. Define HPC3_ZEROIZE_EN to clear shares on drain.
`timescale 1ns/1ps
module shared_hpc3_mul_gfn #(
  parameter int         N      = 4,
  parameter logic [8:0] POLY   = 9'h013,
  parameter int         SHARES = 2,
  localparam int        NP     = SHARES * (SHARES - 1) / 2
) (
  input  logic                  ClkxCI,
  input  logic                  RstxBI,
  input  logic                  InValidxSI,
  output logic                  InReadyxSO,
  input  logic [N*SHARES-1:0]   XxDI,
  input  logic [N*SHARES-1:0]   YxDI,
  input  logic [N*NP-1:0]       ZxDI,
  input  logic [N*NP-1:0]       RxDI,
  output logic                  OutValidxSO,
  input  logic                  OutReadyxSI,
  output logic [N*SHARES-1:0]   QxDO
);

  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] acc;
    logic [N-1:0] sh;
    acc = '0;
    sh  = a;
    for (int k = 0; k < N; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = {sh[N-2:0], 1'b0} ^ (sh[N-1] ? POLY[N-1:0] : {N{1'b0}});
    end
    return acc;
  endfunction

  function automatic int pidx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo + hi * (hi - 1) / 2;
  endfunction

  logic [N-1:0] ff_q [SHARES][SHARES];
  logic [N-1:0] ff_d [SHARES][SHARES];
  logic [N-1:0] b_q  [SHARES][SHARES];
  logic [N-1:0] b_d  [SHARES][SHARES];
  logic [N-1:0] xp_q [SHARES];
  logic [N-1:0] xp_d [SHARES];
  logic         vld_q, vld_d;
  logic         load;

  assign InReadyxSO  = ~vld_q | OutReadyxSI;
  assign OutValidxSO = vld_q;
  assign load        = InValidxSI & InReadyxSO;

  // Each cross term is registered on its own; nothing from two shares meets before a flop.
  always_comb begin
    ff_d  = ff_q;
    b_d   = b_q;
    xp_d  = xp_q;
    vld_d = vld_q;
    if (load) begin
      vld_d = 1'b1;
      for (int i = 0; i < SHARES; i++) begin
        xp_d[i] = XxDI[i*N +: N];
        for (int j = 0; j < SHARES; j++) begin
          if (i == j) begin
            ff_d[i][j] = gf_mul(XxDI[i*N +: N], YxDI[i*N +: N]);
            b_d[i][j]  = '0;
          end else begin
            ff_d[i][j] = gf_mul(XxDI[i*N +: N], ZxDI[pidx(i, j)*N +: N]) ^ RxDI[pidx(i, j)*N +: N];
            b_d[i][j]  = YxDI[j*N +: N] ^ ZxDI[pidx(i, j)*N +: N];
          end
        end
      end
    end else if (vld_q & OutReadyxSI) begin
      vld_d = 1'b0;
`ifdef HPC3_ZEROIZE_EN
      for (int i = 0; i < SHARES; i++) begin
        xp_d[i] = '0;
        for (int j = 0; j < SHARES; j++) begin
          ff_d[i][j] = '0;
          b_d[i][j]  = '0;
        end
      end
`endif
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      vld_q <= 1'b0;
      for (int i = 0; i < SHARES; i++) begin
        xp_q[i] <= '0;
        for (int j = 0; j < SHARES; j++) begin
          ff_q[i][j] <= '0;
          b_q[i][j]  <= '0;
        end
      end
    end else begin
      vld_q <= vld_d;
      xp_q  <= xp_d;
      ff_q  <= ff_d;
      b_q   <= b_d;
    end
  end

  always_comb begin
    QxDO = '0;
    for (int i = 0; i < SHARES; i++) begin
      QxDO[i*N +: N] = ff_q[i][i];
      for (int j = 0; j < SHARES; j++) begin
        if (j != i) QxDO[i*N +: N] = QxDO[i*N +: N] ^ ff_q[i][j] ^ gf_mul(xp_q[i], b_q[i][j]);
      end
    end
  end

endmodule

// File: tb/tb_shared_hpc3_mul_gfn.sv
// Scoreboard bench: GF(256) 3-share instance and GF(16) 2-share instance; drivers push expected
// products, negedge monitors pop and compare the recombined output shares.
`timescale 1ns/1ps
module tb_shared_hpc3_mul_gfn;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  logic        a_in_vld, a_in_rdy, a_out_vld, a_out_rdy;
  logic [23:0] a_x, a_y, a_z, a_r, a_q;
  logic        b_in_vld, b_in_rdy, b_out_vld, b_out_rdy;
  logic [7:0]  b_x, b_y, b_q;
  logic [3:0]  b_z, b_r;

  shared_hpc3_mul_gfn #(.N(8), .POLY(9'h11B), .SHARES(3)) u_a (
    .ClkxCI(clk), .RstxBI(rst_n), .InValidxSI(a_in_vld), .InReadyxSO(a_in_rdy),
    .XxDI(a_x), .YxDI(a_y), .ZxDI(a_z), .RxDI(a_r),
    .OutValidxSO(a_out_vld), .OutReadyxSI(a_out_rdy), .QxDO(a_q));

  shared_hpc3_mul_gfn #(.N(4), .POLY(9'h013), .SHARES(2)) u_b (
    .ClkxCI(clk), .RstxBI(rst_n), .InValidxSI(b_in_vld), .InReadyxSO(b_in_rdy),
    .XxDI(b_x), .YxDI(b_y), .ZxDI(b_z), .RxDI(b_r),
    .OutValidxSO(b_out_vld), .OutReadyxSI(b_out_rdy), .QxDO(b_q));

  logic [7:0] a_exp [$];
  logic [3:0] b_exp [$];

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [7:0] ref_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (15'(a) << k);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'(9'h11B) << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [23:0] a_share(input logic [7:0] v);
    logic [7:0] s0, s1;
    s0 = 8'($urandom);
    s1 = 8'($urandom);
    return {v ^ s0 ^ s1, s1, s0};
  endfunction

  function automatic logic [7:0] b_share(input logic [3:0] v);
    logic [3:0] s0;
    s0 = 4'($urandom);
    return {v ^ s0, s0};
  endfunction

  task automatic a_drive(input logic [23:0] xs, input logic [23:0] ys,
                         input logic [23:0] zs, input logic [23:0] rs, input logic [7:0] e);
    int t;
    t = 0;
    a_x = xs; a_y = ys; a_z = zs; a_r = rs; a_in_vld = 1'b1;
    do begin @(negedge clk); t++; end while (!a_in_rdy && t < 200);
    if (!a_in_rdy) begin n_chk++; $display("FAIL a_accept_timeout: in_rdy stuck at 0"); end
    else a_exp.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic a_send(input logic [7:0] xv, input logic [7:0] yv, input logic [7:0] e);
    a_drive(a_share(xv), a_share(yv), 24'($urandom), 24'($urandom), e);
  endtask

  task automatic b_drive(input logic [7:0] xs, input logic [7:0] ys,
                         input logic [3:0] zs, input logic [3:0] rs, input logic [3:0] e);
    int t;
    t = 0;
    b_x = xs; b_y = ys; b_z = zs; b_r = rs; b_in_vld = 1'b1;
    do begin @(negedge clk); t++; end while (!b_in_rdy && t < 200);
    if (!b_in_rdy) begin n_chk++; $display("FAIL b_accept_timeout: in_rdy stuck at 0"); end
    else b_exp.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic b_send(input logic [3:0] xv, input logic [3:0] yv, input logic [3:0] e);
    b_drive(b_share(xv), b_share(yv), 4'($urandom), 4'($urandom), e);
  endtask

  always @(negedge clk) begin
    if (rst_n && a_out_vld && a_out_rdy) begin
      if (a_exp.size() == 0) begin
        n_chk++;
        $display("FAIL a_unexpected_out: q=%h with empty scoreboard", a_q);
      end else check("a_product", 24'(a_q[7:0] ^ a_q[15:8] ^ a_q[23:16]), 24'(a_exp.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_out_vld && b_out_rdy) begin
      if (b_exp.size() == 0) begin
        n_chk++;
        $display("FAIL b_unexpected_out: q=%h with empty scoreboard", b_q);
      end else check("b_product", 24'(b_q[3:0] ^ b_q[7:4]), 24'(b_exp.pop_front()));
    end
  end

  // AES-field reference pairs: 57*83=C1, 57*13=FE, 02*87=15, 53*CA=01, 02*80=1B
  logic [7:0] dv_x [7] = '{8'h57, 8'h57, 8'h02, 8'h53, 8'h02, 8'h01, 8'h00};
  logic [7:0] dv_y [7] = '{8'h83, 8'h13, 8'h87, 8'hCA, 8'h80, 8'hA5, 8'hFF};
  logic [7:0] dv_e [7] = '{8'hC1, 8'hFE, 8'h15, 8'h01, 8'h1B, 8'hA5, 8'h00};

  logic [23:0] q_hold, xs, ys, zs;
  logic [7:0]  xv, yv;
  logic        done;

  initial begin
    rst_n = 1'b0;
    a_in_vld = 1'b0; a_out_rdy = 1'b1; a_x = '0; a_y = '0; a_z = '0; a_r = '0;
    b_in_vld = 1'b0; b_out_rdy = 1'b1; b_x = '0; b_y = '0; b_z = '0; b_r = '0;
    done = 1'b0;
    #12;
    check("rst_a_out_vld", 24'(a_out_vld), 24'h0);
    check("rst_a_in_rdy",  24'(a_in_rdy),  24'h1);
    check("rst_a_q",       a_q,            24'h0);
    check("rst_b_out_vld", 24'(b_out_vld), 24'h0);
    check("rst_b_q",       24'(b_q),       24'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // GF(16): x=7 as shares 3/4, y=B as 9/2; 7*B reduces to x^2 = 4
    b_drive(8'h43, 8'h29, 4'($urandom), 4'($urandom), 4'h4);
    check("b_latency_vld", 24'(b_out_vld), 24'h1);
    b_send(4'h2, 4'h8, 4'h3);
    b_send(4'h9, 4'h9, 4'hD);
    b_send(4'hF, 4'hF, 4'hA);
    b_send(4'h0, 4'h5, 4'h0);
    b_in_vld = 1'b0;

    for (int k = 0; k < 7; k++) begin
      a_send(dv_x[k], dv_y[k], dv_e[k]);
      if (k == 0) check("a_latency_vld", 24'(a_out_vld), 24'h1);
    end
    a_in_vld = 1'b0;
    @(posedge clk); #1;

    // backpressure: stall the first result, queue a second operand behind it
    a_out_rdy = 1'b0;
    a_send(8'h57, 8'h83, 8'hC1);
    q_hold = a_q;
    fork
      a_send(8'h53, 8'hCA, 8'h01);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_in_rdy",  24'(a_in_rdy),  24'h0);
          check("bp_out_vld", 24'(a_out_vld), 24'h1);
          check("bp_q_hold",  a_q,            q_hold);
        end
        @(posedge clk); #1 a_out_rdy = 1'b1;
        @(negedge clk);
        check("bp_drain_in_rdy", 24'(a_in_rdy), 24'h1);
      end
    join
    check("bp_no_bubble", 24'(a_out_vld), 24'h1);
    a_in_vld = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset while a result is stalled
    a_out_rdy = 1'b0;
    a_send(8'h02, 8'h87, 8'h15);
    a_in_vld = 1'b0;
    #2;
    a_exp.delete();
    rst_n = 1'b0;
    #1;
    check("arst_out_vld", 24'(a_out_vld), 24'h0);
    check("arst_q",       a_q,            24'h0);
    check("arst_in_rdy",  24'(a_in_rdy),  24'h1);
    @(negedge clk); #2;
    rst_n = 1'b1;
    a_out_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("arst_no_spurious_vld", 24'(a_out_vld), 24'h0);
    end
    @(posedge clk); #1;

    // drain without a new load
    a_send(8'h57, 8'h13, 8'hFE);
    a_in_vld = 1'b0;
    q_hold = a_q;
    @(posedge clk); #1;
    check("drain_out_vld", 24'(a_out_vld), 24'h0);
`ifdef HPC3_ZEROIZE_EN
    check("drain_zeroize_q", a_q, 24'h0);
`else
    check("drain_retain_q", a_q, q_hold);
`endif

    // same sharings and z, r01 flipped by 5A: shares 0 and 1 both move by 5A
    xs = a_share(8'h57);
    ys = a_share(8'h83);
    zs = 24'($urandom);
    a_drive(xs, ys, zs, 24'h000000, 8'hC1);
    q_hold = a_q;
    a_drive(xs, ys, zs, 24'h00005A, 8'hC1);
    a_in_vld = 1'b0;
    check("rand_share_delta", a_q ^ q_hold, 24'h005A5A);
    @(posedge clk); #1;

    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          xv = 8'($urandom);
          yv = 8'($urandom);
          a_send(xv, yv, ref_mul8(xv, yv));
        end
        a_in_vld = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1 a_out_rdy = ($urandom_range(0, 3) != 0);
        end
        a_out_rdy = 1'b1;
      end
    join

    for (int t = 0; t < 50 && (a_exp.size() != 0 || b_exp.size() != 0); t++) @(negedge clk);
    check("scoreboard_drained", 24'(a_exp.size() + b_exp.size()), 24'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
